// File: rtl/rr_shift_ctrl_pkg.sv
// Shared types and constants for the 256-bit shift-register controller.
package rr_shift_ctrl_pkg;
  localparam int NWORDS = 16;
  localparam int WORD_W = 16;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_SHIFT = 2'd1;
  localparam logic [1:0] OP_SET   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_SHIFT, ST_SET, ST_DONE
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic       sin;
  } cmd_t;
endpackage

// File: rtl/rr_down_counter.sv
// Loadable down counter with a zero flag; load wins over decrement.
module rr_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/rr_shift_ctrl.sv
// Command sequencer driving load/shift/preset of a 256-bit word-loadable
// right-shift register.
module rr_shift_ctrl
  import rr_shift_ctrl_pkg::*;
#(
  parameter int NWORDS = rr_shift_ctrl_pkg::NWORDS,
  parameter int CNTW   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CNTW-1:0]   cmd_cnt,
  input  logic              cmd_sin,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [WORD_W-1:0] din,
  input  logic              sin,
  output logic              reg_we,
  output logic              reg_sel_rs,
  output logic              reg_set,
  output logic [WORD_W-1:0] reg_regin,
  output logic              reg_bit256,
  output logic              busy,
  output logic              done
);
  localparam int WW    = $clog2(NWORDS);
  localparam int NBITS = NWORDS * WORD_W;

  state_t          state, next;
  cmd_t            cmd_q;
  logic            accept;
  logic [WW-1:0]   wcnt;
  logic [CNTW-1:0] scnt, sload;
  logic            wzero, szero, wdec, sdec;

  assign accept = cmd_valid && cmd_ready;
  // Counters hold (remaining - 1) so the zero flag marks the final cycle.
  assign sload  = (cmd_cnt == '0) ? CNTW'(NBITS - 1) : cmd_cnt - CNTW'(1);
  assign wdec   = (state == ST_LOAD) && din_valid && !wzero;
  assign sdec   = (state == ST_SHIFT) && !szero;

  rr_down_counter #(.W(WW)) u_wcnt (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_val(WW'(NWORDS - 1)),
    .dec(wdec), .cnt(wcnt), .zero(wzero)
  );

  rr_down_counter #(.W(CNTW)) u_scnt (
    .clk(clk), .rst_n(rst_n), .load(accept), .load_val(sload),
    .dec(sdec), .cnt(scnt), .zero(szero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cmd_q <= '0;
    end else begin
      state <= next;
      if (accept) cmd_q <= '{op: cmd_op, sin: cmd_sin};
    end
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE:
        if (accept) begin
          case (cmd_op)
            OP_LOAD:  next = ST_LOAD;
            OP_SHIFT: next = ST_SHIFT;
            OP_SET:   next = ST_SET;
            default:  next = ST_DONE;
          endcase
        end
      ST_LOAD:  if (din_valid && wzero) next = ST_DONE;
      ST_SHIFT: if (szero) next = ST_DONE;
      ST_SET:   next = ST_DONE;
      ST_DONE:  next = ST_IDLE;
      default:  next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state == ST_IDLE);
    busy       = (state != ST_IDLE);
    din_ready  = 1'b0;
    reg_we     = 1'b0;
    reg_sel_rs = 1'b0;
    reg_set    = 1'b0;
    reg_regin  = '0;
    reg_bit256 = 1'b0;
    done       = 1'b0;
    case (state)
      ST_LOAD: begin
        din_ready = 1'b1;
        reg_we    = din_valid;
        reg_regin = din;
      end
      ST_SHIFT: begin
        reg_we     = 1'b1;
        reg_sel_rs = (cmd_q.op == OP_SHIFT);
        reg_bit256 = cmd_q.sin & sin;
      end
      ST_SET: begin
        reg_we  = 1'b1;
        reg_set = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  logic unused;
  assign unused = ^{wcnt, scnt};
endmodule

// File: tb/tb_rr_shift_ctrl.sv
// Directed bench for rr_shift_ctrl: reset, LOAD with gaps, SHIFT 5/256,
// SET with hold-off, reserved op, and reset abort mid-shift.
module tb_rr_shift_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [8:0]  cmd_cnt = '0;
  logic        cmd_sin = 1'b0;
  logic        din_valid = 1'b0, din_ready;
  logic [15:0] din = '0;
  logic        sin = 1'b0;
  logic        reg_we, reg_sel_rs, reg_set, reg_bit256, busy, done;
  logic [15:0] reg_regin;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  rr_shift_ctrl #(.NWORDS(16), .CNTW(9)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_sin(cmd_sin),
    .din_valid(din_valid), .din_ready(din_ready), .din(din), .sin(sin),
    .reg_we(reg_we), .reg_sel_rs(reg_sel_rs), .reg_set(reg_set),
    .reg_regin(reg_regin), .reg_bit256(reg_bit256), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer a command in IDLE; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [8:0] cnt, input logic s);
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_sin = s;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_shift(input logic [8:0] cnt, input logic s, input int exp_n, input logic exp_bit);
    int n = 0, nbit = 0, nsel = 0, donec = -1;
    issue(2'd1, cnt, s);
    for (int c = 0; c < 400 && donec < 0; c++) begin
      @(negedge clk);
      if (reg_we) begin
        n++;
        if (reg_bit256 !== exp_bit) nbit++;
        if (reg_sel_rs !== 1'b1) nsel++;
      end
      if (done) donec = c;
      tick();
    end
    chk("shift_cycles", n, exp_n);
    chk("shift_done_at", donec, exp_n);
    chk("shift_bit256_errs", nbit, 0);
    chk("shift_sel_errs", nsel, 0);
  endtask

  task automatic do_set(input logic holdoff);
    issue(2'd2, 9'd0, 1'b0);
    if (holdoff) begin cmd_valid = 1'b1; cmd_op = 2'd1; cmd_cnt = 9'd3; end
    @(negedge clk);
    chk("set_reg_set", reg_set, 1);
    chk("set_reg_we", reg_we, 1);
    chk("set_no_done", done, 0);
    if (holdoff) chk("set_holdoff", cmd_ready, 0);
    tick();
    @(negedge clk);
    chk("set_done", done, 1);
    chk("set_done_we", reg_we, 0);
    chk("set_done_regset", reg_set, 0);
    if (holdoff) chk("done_holdoff", cmd_ready, 0);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("set_back_idle", cmd_ready, 1);
    chk("set_idle_busy", busy, 0);
    tick();
  endtask

  initial begin
    int we_n, last, donec, ndone;
    // Reset
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_done", done, 0);
    chk("rst_din_ready", din_ready, 0);
    tick(); rst_n = 1'b1; tick();

    // din offered while idle is ignored
    din_valid = 1'b1; din = 16'hBEEF;
    @(negedge clk);
    chk("idle_din_ready", din_ready, 0);
    chk("idle_reg_we", reg_we, 0);
    chk("idle_regin", reg_regin, 0);
    tick(); din_valid = 1'b0;

    // LOAD 0..15 with din_valid low every other cycle
    issue(2'd0, 9'd0, 1'b0);
    we_n = 0; last = -1; donec = -1;
    for (int c = 0; c < 80 && donec < 0; c++) begin
      din_valid = (c % 2 == 0);
      din = 16'(we_n);
      @(negedge clk);
      chk("load_we", reg_we, din_valid && (we_n < 16));
      chk("load_din_ready", din_ready, we_n < 16);
      if (reg_we) begin
        chk("load_word", reg_regin, we_n);
        chk("load_sel", reg_sel_rs, 0);
        we_n++; last = c;
      end
      if (done) donec = c;
      tick();
    end
    din_valid = 1'b0;
    chk("load_beats", we_n, 16);
    chk("load_done_at", donec, last + 1);
    @(negedge clk);
    chk("load_idle", cmd_ready, 1);
    tick();

    sin = 1'b1;
    do_shift(9'd5, 1'b1, 5, 1'b1);
    do_shift(9'd0, 1'b0, 256, 1'b0);
    do_shift(9'd1, 1'b1, 1, 1'b1);

    do_set(1'b1);

    // Reserved op: straight to DONE, no write
    issue(2'd3, 9'd0, 1'b0);
    @(negedge clk);
    chk("rsv_done", done, 1);
    chk("rsv_we", reg_we, 0);
    tick();

    // Reset at shift 100 of 256
    sin = 1'b0;
    issue(2'd1, 9'd0, 1'b1);
    repeat (99) tick();
    @(negedge clk);
    chk("abort_pre_we", reg_we, 1);
    #2 rst_n = 1'b0; #1;
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_we", reg_we, 0);
    chk("abort_done", done, 0);
    tick(); rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
      tick();
    end
    chk("abort_no_done", ndone, 0);
    do_set(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got hang want finish");
    $fatal(1);
  end
endmodule

// File: doc/rr_shift_ctrl.md
RR_SHIFT_CTRL -- requirements
Module: rr_shift_ctrl

Interface
REQ-001 SHALL have parameter NWORDS, default 16, number of 16-bit words in the controlled 256-bit shift register.
REQ-002 SHALL have parameter CNTW, default 9, width of the shift counter.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid&cmd_ready.
REQ-008 cmd_op  input  2  command: 0 LOAD, 1 SHIFT, 2 SET, 3 reserved.
REQ-009 cmd_cnt  input  CNTW  SHIFT count; 0 encodes 256.
REQ-010 cmd_sin  input  1  SHIFT fill source: 0 constant 0, 1 external sin.
REQ-011 din_valid  input  1  load word offered.
REQ-012 din_ready  output  1  load word accepted when din_valid&din_ready.
REQ-013 din  input  16  load word, least-significant word first.
REQ-014 sin  input  1  external serial fill bit.
REQ-015 reg_we  output  1  register write enable.
REQ-016 reg_sel_rs  output  1  0 = 16-bit word load, 1 = 1-bit right shift.
REQ-017 reg_set  output  1  preset register to value 1.
REQ-018 reg_regin  output  16  word to the register load input.
REQ-019 reg_bit256  output  1  MSB fill bit during a shift.
REQ-020 busy  output  1  high in any state other than IDLE.
REQ-021 done  output  1  one-cycle pulse when a command completes.

Function
REQ-022 States SHALL be IDLE, LOAD, SHIFT, SET, DONE; cmd_ready = (state==IDLE).
REQ-023 Accepting a command SHALL latch cmd_op, cmd_cnt and cmd_sin and, on the next edge, enter LOAD, SHIFT or SET; op 3 SHALL go directly to DONE with no register write.
REQ-024 LOAD: din_ready=1; each accepted beat SHALL drive reg_we=1, reg_sel_rs=0, reg_regin=din in the same cycle (combinational pass-through, zero latency).
REQ-025 LOAD: cycles with din_valid=0 SHALL drive reg_we=0 and SHALL NOT advance the 4-bit word counter.
REQ-026 LOAD SHALL exit to DONE after exactly NWORDS accepted beats; the word counter SHALL wrap to 0.
REQ-027 SHIFT: each cycle SHALL drive reg_we=1, reg_sel_rs=1, reg_bit256 = latched cmd_sin ? sin : 0, and decrement the shift counter.
REQ-028 SHIFT SHALL last exactly N cycles (N = cmd_cnt, or 256 when cmd_cnt=0), then go to DONE.
REQ-029 SET SHALL last one cycle with reg_set=1 and reg_we=1, then go to DONE.
REQ-030 DONE SHALL last one cycle with done=1 and reg_we=0, then return to IDLE; the next command SHALL be accepted no earlier than the following cycle.
REQ-031 Outside LOAD, SHIFT and SET, reg_we, reg_set and din_ready SHALL be 0; reg_set SHALL be 0 outside SET.
REQ-032 reg_regin SHALL be 0 outside LOAD and reg_bit256 SHALL be 0 outside SHIFT.
REQ-033 din beats offered outside LOAD SHALL be ignored, with din_ready=0.

Reset
REQ-034 rst_n low SHALL force state IDLE, clear both counters and latched fields, and force all outputs to 0 except cmd_ready, which SHALL be 1 after reset.
REQ-035 Reset asserted mid-LOAD or mid-SHIFT SHALL abort the command with no done pulse; register contents are then undefined to the user.

Structure
REQ-036 A shared package SHALL hold the state enum, the op codes (OP_LOAD, OP_SHIFT, OP_SET) and NWORDS.
REQ-037 The shift/word counter SHALL be one sub-module, rr_down_counter (load, decrement, zero flag); one instance per counter.

Verification
REQ-038 Reset release -> cmd_ready=1; busy, reg_we, done=0.
REQ-039 LOAD with 16 words 0x0000..0x000F, din_valid low every other cycle -> exactly 16 reg_we pulses in order; done pulses on the cycle after beat 16.
REQ-040 SHIFT with cmd_cnt=5, cmd_sin=1, sin=1 -> exactly 5 cycles of reg_we=1, reg_sel_rs=1, reg_bit256=1; then done.
REQ-041 SHIFT with cmd_cnt=0 -> exactly 256 shift cycles before done.
REQ-042 SET -> one cycle of reg_set=1 and reg_we=1; done on the next cycle; a command offered during busy is held off (cmd_ready=0).
REQ-043 rst_n pulsed low at shift 100 of 256 -> immediate IDLE, no done pulse, and a subsequent SET completes normally.
